counter_seq_ctrl: RTL

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl_if.sv | 29 ++
 rtl/counter_seq_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl_if.sv
// rtl/counter_seq_ctrl_if.sv - command and counter-control bundle for counter_seq_ctrl
// master: command source plus the controlled counter; slave: the sequencing controller.
interface counter_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_start;
   logic [WIDTH-1:0] cmd_term;
   logic             cmd_reload;
   logic [WIDTH-1:0] cnt_q;
   logic             cnt_load;
   logic             cnt_enable;
   logic [WIDTH-1:0] cnt_load_value;
   logic             busy;
   logic             done;
   logic [3:0]       wraps;

   modport master (
      output cmd_valid, cmd_op, cmd_start, cmd_term, cmd_reload, cnt_q,
      input  cmd_ready, cnt_load, cnt_enable, cnt_load_value, busy, done, wraps
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_start, cmd_term, cmd_reload, cnt_q,
      output cmd_ready, cnt_load, cnt_enable, cnt_load_value, busy, done, wraps
   );
endinterface

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - START/PAUSE/RESUME/ABORT sequencer driving an external load/enable counter
// Registered outputs except cnt_enable and cmd_ready, which decode directly from state.
module counter_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   counter_seq_ctrl_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RUN    = 3'd2,
      S_PAUSED = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_PAUSE  = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_ABORT  = 2'b11;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] term_q, term_d;
   logic             reload_q, reload_d;
   logic [3:0]       wraps_q, wraps_d;
   logic             cnt_load_q, cnt_load_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic cmd_ready;
   logic cmd_acc;
   logic term_hit;

   assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_PAUSED);
   assign cmd_acc   = bus.cmd_valid && cmd_ready;
   assign term_hit  = (bus.cnt_q == term_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         start_q    <= '0;
         term_q     <= '0;
         reload_q   <= 1'b0;
         wraps_q    <= 4'd0;
         cnt_load_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         term_q     <= term_d;
         reload_q   <= reload_d;
         wraps_q    <= wraps_d;
         cnt_load_q <= cnt_load_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   // ABORT outranks the terminal match, which in turn outranks PAUSE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_acc && bus.cmd_op == OP_START) state_d = S_LOAD;
         end
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            if (cmd_acc && bus.cmd_op == OP_ABORT)      state_d = S_IDLE;
            else if (term_hit)                          state_d = reload_q ? S_LOAD : S_DONE;
            else if (cmd_acc && bus.cmd_op == OP_PAUSE) state_d = S_PAUSED;
         end
         S_PAUSED: begin
            if (cmd_acc && bus.cmd_op == OP_RESUME)     state_d = S_RUN;
            else if (cmd_acc && bus.cmd_op == OP_ABORT) state_d = S_IDLE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_d  = start_q;
      term_d   = term_q;
      reload_d = reload_q;
      wraps_d  = wraps_q;
      if (state_q == S_IDLE && cmd_acc && bus.cmd_op == OP_START) begin
         start_d  = bus.cmd_start;
         term_d   = bus.cmd_term;
         reload_d = bus.cmd_reload;
         wraps_d  = 4'd0;
      end else if (state_q == S_RUN && state_d == S_LOAD && wraps_q != 4'hF) begin
         wraps_d  = wraps_q + 4'd1;
      end
      cnt_load_d = (state_d == S_LOAD);
      done_d     = (state_d == S_DONE);
      busy_d     = (state_d != S_IDLE);
   end

   assign bus.cmd_ready      = cmd_ready;
   assign bus.cnt_enable     = (state_q == S_RUN) && !term_hit;
   assign bus.cnt_load       = cnt_load_q;
   assign bus.cnt_load_value = start_q;
   assign bus.done           = done_q;
   assign bus.busy           = busy_q;
   assign bus.wraps          = wraps_q;
endmodule
